bank_group_ctrl: RTL and testbench
==================================

Name: bank_group_ctrl

Overview:
Command sequencer in front of a BankGroup of 2**BAWIDTH Banks. It accepts one ACT/RD/WR/PRE command per cycle over a valid/ready handshake and tracks per-bank open/closed state. It enforces tRCD, tRP and tCCD timing and drives the BankGroup's per-bank rd_o_wr/row/column bundles. Illegal commands are flagged and dropped, never forwarded.

Parameters:
BAWIDTH, 2, log2 of banks per group; BANKSPERGROUP = 2**BAWIDTH (localparam).
COLWIDTH, 10, column address width.
CHWIDTH, 5, row address width.
T_RCD, 3, cycles from ACT accept to earliest RD/WR accept on that bank (minimum 1).
T_RP, 3, cycles from PRE accept to earliest ACT accept on that bank (minimum 1).
T_CCD, 2, cycles between consecutive RD/WR accepts, any banks (minimum 1).

Ports:
clk  in  1  clock; all state changes on posedge.
reset  in  1  synchronous, active-high.
cmd_valid  in  1  command present.
cmd_ready  out  1  command accepted this cycle when valid&ready.
cmd_op  in  2  0=ACT, 1=RD, 2=WR, 3=PRE.
cmd_bank  in  BAWIDTH  target bank.
cmd_row  in  CHWIDTH  row, used by ACT only.
cmd_col  in  COLWIDTH  column, used by RD/WR only.
cmd_err  out  1  one-cycle pulse, cycle after an illegal command is accepted.
bank_open  out  BANKSPERGROUP  bit b=1 while bank b is ACTIVE.
rd_valid  out  1  pulse one cycle after a RD is driven; BankGroup dqout[rd_bank] valid.
rd_bank  out  BAWIDTH  bank of the current rd_valid.
rd_o_wr  out  [0:0] x BANKSPERGROUP unpacked  per-bank write strobe to BankGroup.
row  out  [CHWIDTH-1:0] x BANKSPERGROUP unpacked  per-bank row to BankGroup.
column  out  [COLWIDTH-1:0] x BANKSPERGROUP unpacked  per-bank column to BankGroup.

Behaviour:
- Reset: all banks IDLE, all counters 0. cmd_err, rd_valid, rd_bank, bank_open and every rd_o_wr/row/column element are 0. Reset overrides any in-flight command or countdown, including mid-operation.
- Per-bank FSM: IDLE -ACT-> ACTIVATING (counter=T_RCD-1; if 0, go straight to ACTIVE) -> ACTIVE when the counter reaches 0. ACTIVE -PRE-> PRECHARGING (counter=T_RP-1) -> IDLE at 0.
- Global ccd counter: loaded with T_CCD-1 on any RD/WR accept; decrements to 0.
- cmd_ready (combinational) = !reset & target bank not ACTIVATING/PRECHARGING & (op not RD/WR or ccd==0). Illegal commands meeting these conditions are accepted.
- Legality:
  - ACT legal only in IDLE.
  - RD/WR legal only in ACTIVE.
  - PRE to IDLE is a legal no-op: no timing applied, no error.
  - Illegal accepts: no state/output change; cmd_err=1 next cycle.
- Latency (accept at edge t):
  - ACT: row[b] loaded at t+1 and held until the next ACT on b.
  - RD: column[b] loaded at t+1; rd_valid=1, rd_bank=b at t+2.
  - WR: column[b] loaded and rd_o_wr[b]=1 for exactly cycle t+1, then 0.
  - Non-target banks' outputs unchanged.
- Timing: ACT at t allows RD/WR on b at t+T_RCD. PRE at t allows ACT on b at t+T_RP. RD/WR at t allows next RD/WR at t+T_CCD. Commands to other banks are unaffected by a bank's tRCD/tRP.
- Back-to-back: a new command may be accepted every cycle subject to the rules above. A command arriving while ready=0 is held by the requester (valid/payload stable until accepted).
- Counter widths: $clog2(max(T_RCD,T_RP,T_CCD)+1); no wrap, saturate at 0.

Decomposition:
- Package bank_group_pkg:
  - cmd_op_e enum {ACT, RD, WR, PRE}.
  - bank_state_e {IDLE, ACTIVATING, ACTIVE, PRECHARGING}.
  - timing defaults.
- Sub-module bank_fsm: one bank's state and countdown. Inputs: clk, reset, do_act, do_pre. Outputs: state, busy. Instanced BANKSPERGROUP times in a generate loop.
- ccd counter, legality decode and output registers stay in the top level.

Test Plan:
- Reset then idle: all outputs 0, cmd_ready=1 for ACT bank 0, bank_open=4'b0000.
- ACT b1 row 5 at t -> row[1]=5 at t+1; RD b1 col 9 held from t+1 -> ready low until t+3. Accept at t+3 -> column[1]=9 at t+4, rd_valid=1, rd_bank=1 at t+5, bank_open=4'b0010.
- With b0 and b2 ACTIVE: WR b0 col 3 at t, WR b2 col 4 presented at t+1 -> accepted at t+2. rd_o_wr[0] high only at t+1, rd_o_wr[2] high only at t+3.
- RD to IDLE b3 and ACT to ACTIVE b1 -> each accepted with cmd_err pulse next cycle, no output/state change. PRE to IDLE b3 -> no err.
- PRE b1 at t, ACT b1 held -> accepted at t+3. ACT b2 at t+1 accepted immediately (independent banks).
- reset asserted while b1 ACTIVATING with count 1 -> next cycle b1 IDLE, bank_open=0, row[1]=0; a RD to b1 is then flagged with cmd_err.

Source files
------------

// File: rtl/bank_group_pkg.sv
// Shared types and timing defaults for the bank group command sequencer.
// Holds the command opcode and per-bank state encodings.
// cnt_width() sizes the countdown registers from the timing parameters.
package bank_group_pkg;

  typedef enum logic [1:0] {
    ACT = 2'd0,
    RD  = 2'd1,
    WR  = 2'd2,
    PRE = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ACTIVATING  = 2'd1,
    ACTIVE      = 2'd2,
    PRECHARGING = 2'd3
  } bank_state_e;

  localparam int DEF_BAWIDTH  = 2;
  localparam int DEF_COLWIDTH = 10;
  localparam int DEF_CHWIDTH  = 5;
  localparam int DEF_T_RCD    = 3;
  localparam int DEF_T_RP     = 3;
  localparam int DEF_T_CCD    = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Countdown width: enough to hold the largest timing value.
  function automatic int cnt_width(input int rcd, input int rp, input int ccd);
    int w;
    w = $clog2(max3(rcd, rp, ccd) + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bank_fsm.sv
// One bank's open/closed state machine with its tRCD/tRP countdown.
// Ports: clk, reset (sync, active-high), do_act/do_pre (legal accepted commands),
//        state (current bank state), busy (ACTIVATING or PRECHARGING).
module bank_fsm
  import bank_group_pkg::*;
#(
  parameter int T_RCD = DEF_T_RCD,
  parameter int T_RP  = DEF_T_RP,
  parameter int CW    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        do_act,
  input  logic        do_pre,
  output bank_state_e state,
  output logic        busy
);

  bank_state_e state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] cnt_dec;

  // Saturating decrement.
  assign cnt_dec = (cnt == '0) ? '0 : cnt - CW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The count holds the remaining busy cycles after the current one, so the
  // bank leaves its transient state on the cycle the count would hit 0.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (do_act) begin
          if (T_RCD <= 1) begin
            state_nxt = ACTIVE;
            cnt_nxt   = '0;
          end else begin
            state_nxt = ACTIVATING;
            cnt_nxt   = CW'(T_RCD - 1);
          end
        end
      end
      ACTIVATING: begin
        cnt_nxt = cnt_dec;
        if (cnt <= CW'(1)) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (do_pre) begin
          if (T_RP <= 1) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            state_nxt = PRECHARGING;
            cnt_nxt   = CW'(T_RP - 1);
          end
        end
      end
      PRECHARGING: begin
        cnt_nxt = cnt_dec;
        if (cnt <= CW'(1)) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy = (state == ACTIVATING) || (state == PRECHARGING);

endmodule

// File: rtl/bank_group_ctrl.sv
// Command sequencer for a bank group: accepts ACT/RD/WR/PRE over valid/ready,
// enforces tRCD/tRP per bank and tCCD across banks, drives per-bank row/column/
// write strobe, flags illegal commands (cmd_err) and signals read data (rd_valid).
// Ports: clk, reset, cmd_valid/cmd_ready/cmd_op/cmd_bank/cmd_row/cmd_col,
//        cmd_err, bank_open, rd_valid, rd_bank, rd_o_wr[], row[], column[].
module bank_group_ctrl
  import bank_group_pkg::*;
#(
  parameter int BAWIDTH  = DEF_BAWIDTH,
  parameter int COLWIDTH = DEF_COLWIDTH,
  parameter int CHWIDTH  = DEF_CHWIDTH,
  parameter int T_RCD    = DEF_T_RCD,
  parameter int T_RP     = DEF_T_RP,
  parameter int T_CCD    = DEF_T_CCD
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [BAWIDTH-1:0]    cmd_bank,
  input  logic [CHWIDTH-1:0]    cmd_row,
  input  logic [COLWIDTH-1:0]   cmd_col,
  output logic                  cmd_err,
  output logic [2**BAWIDTH-1:0] bank_open,
  output logic                  rd_valid,
  output logic [BAWIDTH-1:0]    rd_bank,
  output logic [0:0]            rd_o_wr [2**BAWIDTH],
  output logic [CHWIDTH-1:0]    row     [2**BAWIDTH],
  output logic [COLWIDTH-1:0]   column  [2**BAWIDTH]
);

  localparam int BANKSPERGROUP = 2**BAWIDTH;
  localparam int CW = cnt_width(T_RCD, T_RP, T_CCD);

  bank_state_e                st [BANKSPERGROUP];
  logic [BANKSPERGROUP-1:0]   busy;
  logic [BANKSPERGROUP-1:0]   do_act;
  logic [BANKSPERGROUP-1:0]   do_pre;
  logic [CW-1:0]              ccd;
  cmd_op_e                    op;
  bank_state_e                tgt;
  logic                       is_rw;
  logic                       accept;
  logic                       legal;
  logic                       act_ok;
  logic                       pre_ok;
  logic                       rw_ok;
  logic                       rd_pend;
  logic [BAWIDTH-1:0]         rd_pend_bank;

  assign op     = cmd_op_e'(cmd_op);
  assign tgt    = st[cmd_bank];
  assign is_rw  = (op == RD) || (op == WR);

  // Transient banks stall everything aimed at them (including illegal
  // commands), so an accepted command only ever sees IDLE or ACTIVE.
  assign cmd_ready = !reset && !busy[cmd_bank] && (!is_rw || (ccd == '0));
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    legal = 1'b1;
    case (op)
      ACT:     legal = (tgt == IDLE);
      RD, WR:  legal = (tgt == ACTIVE);
      default: legal = 1'b1;  // PRE to an IDLE bank is a silent no-op
    endcase
  end

  assign act_ok = accept && (op == ACT) && legal;
  assign pre_ok = accept && (op == PRE) && (tgt == ACTIVE);
  assign rw_ok  = accept && is_rw && legal;

  for (genvar b = 0; b < BANKSPERGROUP; b++) begin : g_bank
    assign do_act[b] = act_ok && (cmd_bank == BAWIDTH'(b));
    assign do_pre[b] = pre_ok && (cmd_bank == BAWIDTH'(b));

    bank_fsm #(
      .T_RCD (T_RCD),
      .T_RP  (T_RP),
      .CW    (CW)
    ) u_bank_fsm (
      .clk    (clk),
      .reset  (reset),
      .do_act (do_act[b]),
      .do_pre (do_pre[b]),
      .state  (st[b]),
      .busy   (busy[b])
    );

    assign bank_open[b] = (st[b] == ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ccd          <= '0;
      cmd_err      <= 1'b0;
      rd_pend      <= 1'b0;
      rd_pend_bank <= '0;
      rd_valid     <= 1'b0;
      rd_bank      <= '0;
      for (int b = 0; b < BANKSPERGROUP; b++) begin
        rd_o_wr[b] <= 1'b0;
        row[b]     <= '0;
        column[b]  <= '0;
      end
    end else begin
      cmd_err <= accept && !legal;

      // Only legal reads/writes reach the bank group, so only they start tCCD.
      if (rw_ok)            ccd <= CW'(T_CCD - 1);
      else if (ccd != '0)   ccd <= ccd - CW'(1);

      // Read data appears one cycle after the column is presented.
      rd_pend <= rw_ok && (op == RD);
      if (rw_ok && (op == RD)) rd_pend_bank <= cmd_bank;
      rd_valid <= rd_pend;
      if (rd_pend) rd_bank <= rd_pend_bank;

      for (int b = 0; b < BANKSPERGROUP; b++) begin
        rd_o_wr[b] <= 1'(rw_ok && (op == WR) && (cmd_bank == BAWIDTH'(b)));
        if (do_act[b]) row[b] <= cmd_row;
        if (rw_ok && (cmd_bank == BAWIDTH'(b))) column[b] <= cmd_col;
      end
    end
  end

endmodule

// File: tb/tb_bank_group_ctrl.sv
// Self-checking bench for bank_group_ctrl: directed scenarios then random traffic.
// A time-based reference model predicts readiness and pushes expected pulses
// into queues; a negedge monitor pops and compares them against the DUT.
module tb_bank_group_ctrl;
  import bank_group_pkg::*;

  localparam int BAW  = 2;
  localparam int NB   = 4;
  localparam int COLW = 10;
  localparam int CHW  = 5;
  localparam int TRCD = 3;
  localparam int TRP  = 3;
  localparam int TCCD = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [1:0]      cmd_op = 2'd0;
  logic [BAW-1:0]  cmd_bank = '0;
  logic [CHW-1:0]  cmd_row = '0;
  logic [COLW-1:0] cmd_col = '0;
  logic            cmd_err;
  logic [NB-1:0]   bank_open;
  logic            rd_valid;
  logic [BAW-1:0]  rd_bank;
  logic [0:0]      rd_o_wr [NB];
  logic [CHW-1:0]  row     [NB];
  logic [COLW-1:0] column  [NB];

  bank_group_ctrl #(
    .BAWIDTH (BAW), .COLWIDTH (COLW), .CHWIDTH (CHW),
    .T_RCD (TRCD), .T_RP (TRP), .T_CCD (TCCD)
  ) dut (
    .clk (clk), .reset (reset),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_op (cmd_op),
    .cmd_bank (cmd_bank), .cmd_row (cmd_row), .cmd_col (cmd_col),
    .cmd_err (cmd_err), .bank_open (bank_open),
    .rd_valid (rd_valid), .rd_bank (rd_bank),
    .rd_o_wr (rd_o_wr), .row (row), .column (column)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; read at a posedge it names that edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int due;
    int bank;
  } ev_t;

  ev_t err_q[$];
  ev_t rd_q[$];
  ev_t wr_q[$];

  // Reference model: a bank is open or closed and unusable before a given cycle.
  bit              m_open       [NB];
  int              m_busy_until [NB];
  int              m_ccd_until;
  logic [CHW-1:0]  m_row        [NB];
  logic [COLW-1:0] m_col        [NB];

  bit mon_en = 1'b0;
  bit last_acc = 1'b0;
  int last_edge = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic void model_clear();
    for (int b = 0; b < NB; b++) begin
      m_open[b] = 1'b0;
      m_busy_until[b] = 0;
      m_row[b] = '0;
      m_col[b] = '0;
    end
    m_ccd_until = 0;
  endfunction

  // Synchronous reset at edge n: pulses already registered before n still show.
  function automatic void model_reset(input int n);
    model_clear();
    while (err_q.size() > 0 && err_q[$].due > n) void'(err_q.pop_back());
    while (rd_q.size()  > 0 && rd_q[$].due  > n) void'(rd_q.pop_back());
    while (wr_q.size()  > 0 && wr_q[$].due  > n) void'(wr_q.pop_back());
  endfunction

  function automatic bit model_ready(input int c);
    int b;
    b = int'(cmd_bank);
    if (reset) return 1'b0;
    if (c < m_busy_until[b]) return 1'b0;
    if ((cmd_op == RD || cmd_op == WR) && c < m_ccd_until) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_accept(input int n);
    int b;
    b = int'(cmd_bank);
    case (cmd_op)
      ACT: begin
        if (!m_open[b]) begin
          m_open[b] = 1'b1;
          m_busy_until[b] = n + TRCD;
          m_row[b] = cmd_row;
        end else err_q.push_back('{n + 1, b});
      end
      RD, WR: begin
        if (m_open[b]) begin
          m_col[b] = cmd_col;
          m_ccd_until = n + TCCD;
          if (cmd_op == RD) rd_q.push_back('{n + 2, b});
          else              wr_q.push_back('{n + 1, b});
        end else err_q.push_back('{n + 1, b});
      end
      default: begin
        if (m_open[b]) begin
          m_open[b] = 1'b0;
          m_busy_until[b] = n + TRP;
        end
      end
    endcase
  endfunction

  // One clock: check readiness mid-cycle, apply the edge to the model, then
  // leave the caller 1 time unit after the edge to drive the next inputs.
  task automatic step();
    int c;
    bit exp_rdy;
    @(negedge clk);
    c = cyc;
    exp_rdy = model_ready(c);
    check(cmd_ready === exp_rdy, "cmd_ready", longint'(cmd_ready), longint'(exp_rdy));
    last_acc = cmd_valid && (cmd_ready === 1'b1);
    @(posedge clk);
    last_edge = c;
    if (reset) model_reset(c);
    else if (last_acc) model_accept(c);
    #1;
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input cmd_op_e op, input int b, input int r, input int c, output int edge_n);
    bit done;
    done = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_bank  = BAW'(b);
    cmd_row   = CHW'(r);
    cmd_col   = COLW'(c);
    for (int k = 0; k < 40 && !done; k++) begin
      step();
      done = last_acc;
    end
    if (!done) check(1'b0, "send_timeout", 0, 1);
    edge_n = last_edge;
    cmd_valid = 1'b0;
  endtask

  // Monitor: consumes expected pulses whenever the DUT shows one or one is due.
  always @(negedge clk) begin
    bit            e;
    logic [NB-1:0] exp_open;
    logic [NB-1:0] wr_vec;
    logic [NB-1:0] wr_exp;
    if (mon_en) begin
      e = (err_q.size() > 0) && (err_q[0].due == cyc);
      if (cmd_err !== 1'b0 || e) begin
        check(cmd_err === e, "cmd_err", longint'(cmd_err), longint'(e));
        if (e) void'(err_q.pop_front());
      end

      e = (rd_q.size() > 0) && (rd_q[0].due == cyc);
      if (rd_valid !== 1'b0 || e) begin
        check(rd_valid === e, "rd_valid", longint'(rd_valid), longint'(e));
        if (e) begin
          check(rd_bank === BAW'(rd_q[0].bank), "rd_bank", longint'(rd_bank), longint'(rd_q[0].bank));
          void'(rd_q.pop_front());
        end
      end

      e = (wr_q.size() > 0) && (wr_q[0].due == cyc);
      wr_exp = '0;
      if (e) wr_exp[wr_q[0].bank] = 1'b1;
      for (int b = 0; b < NB; b++) wr_vec[b] = rd_o_wr[b][0];
      if (wr_vec !== '0 || e) begin
        check(wr_vec === wr_exp, "rd_o_wr", longint'(wr_vec), longint'(wr_exp));
        if (e) void'(wr_q.pop_front());
      end

      for (int b = 0; b < NB; b++) exp_open[b] = m_open[b] && (cyc >= m_busy_until[b]);
      check(bank_open === exp_open, "bank_open", longint'(bank_open), longint'(exp_open));

      for (int b = 0; b < NB; b++) begin
        check(row[b] === m_row[b], $sformatf("row[%0d]", b), longint'(row[b]), longint'(m_row[b]));
        check(column[b] === m_col[b], $sformatf("column[%0d]", b), longint'(column[b]), longint'(m_col[b]));
      end
    end
  end

  initial begin
    int t;
    int t2;
    int e;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    step();
    check(rd_bank === '0, "reset_rd_bank", longint'(rd_bank), 0);
    reset = 1'b0;
    idle(2);

    // Activate then read one bank: RD stalls for tRCD.
    send(ACT, 1, 5, 0, t);
    send(RD, 1, 0, 9, e);
    check(e == t + TRCD, "trcd_accept_edge", e, t + TRCD);

    // Writes to two open banks are spaced by tCCD.
    send(ACT, 0, 2, 0, e);
    send(ACT, 2, 3, 0, e);
    idle(4);
    send(WR, 0, 0, 3, t);
    send(WR, 2, 0, 4, e);
    check(e == t + TCCD, "tccd_accept_edge", e, t + TCCD);
    idle(2);

    // Illegal commands and the PRE-to-idle no-op.
    send(RD, 3, 0, 1, e);
    send(ACT, 1, 7, 0, e);
    send(PRE, 3, 0, 0, e);
    idle(3);

    // Precharge stalls only its own bank.
    send(PRE, 1, 0, 0, t);
    send(ACT, 3, 9, 0, t2);
    check(t2 == t + 1, "indep_bank_edge", t2, t + 1);
    send(ACT, 1, 11, 0, e);
    check(e == t + TRP, "trp_accept_edge", e, t + TRP);
    idle(4);

    // Reset while a bank is mid-activation, then a read to it is illegal.
    send(PRE, 1, 0, 0, e);
    idle(3);
    send(ACT, 1, 13, 0, t);
    idle(1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    send(RD, 1, 0, 2, e);
    idle(3);

    // Random traffic with held payloads and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if (!cmd_valid || last_acc) begin
        cmd_valid = ($urandom_range(0, 3) != 0);
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_bank  = BAW'($urandom_range(0, NB - 1));
        cmd_row   = CHW'($urandom);
        cmd_col   = COLW'($urandom);
      end
      reset = ($urandom_range(0, 249) == 0);
      step();
    end
    reset = 1'b0;
    idle(5);

    check(err_q.size() == 0, "err_q_drained", err_q.size(), 0);
    check(rd_q.size() == 0, "rd_q_drained", rd_q.size(), 0);
    check(wr_q.size() == 0, "wr_q_drained", wr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
